// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle controller: states, opcodes, ALU ops, PC sources
// and the bundled control-strobe record driven by the FSM.
package multicycle_control_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWR  = 4'd4,
        S_WB_ACC = 4'd5,
        S_WB_MEM = 4'd6,
        S_STORE  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_HALT   = 4'd10
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_LW   = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_ORI  = 4'h6;
    localparam logic [3:0] OP_ST   = 4'h7;
    localparam logic [3:0] OP_SW   = 4'h9;
    localparam logic [3:0] OP_LI   = 4'hA;
    localparam logic [3:0] OP_BEZ  = 4'hB;
    localparam logic [3:0] OP_J    = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_ADD    = 3'd0;
    localparam logic [2:0] ALU_SUB    = 3'd1;
    localparam logic [2:0] ALU_AND    = 3'd2;
    localparam logic [2:0] ALU_OR     = 3'd3;
    localparam logic [2:0] ALU_PASS_A = 3'd4;
    localparam logic [2:0] ALU_PASS_B = 3'd5;

    localparam logic [1:0] PCSRC_INC = 2'd0;
    localparam logic [1:0] PCSRC_REL = 2'd1;
    localparam logic [1:0] PCSRC_ABS = 2'd2;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       mdr_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       a_write;
        logic       b_write;
        logic       a_sel;
        logic       b_sel;
        logic       itype_sel;
        logic [2:0] alu_op;
        logic       aluout_write;
        logic       acc_write;
        logic       acc_src;
        logic       reg_write;
        logic       iszero_write;
        logic       illegal;
    } ctrl_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        return !((op == 4'h8) || (op == 4'hD) || (op == 4'hE));
    endfunction

endpackage

// File: rtl/ctrl_alu_decode.sv
// Combinational opcode decode: ALU operation for EXEC and operand/immediate selects for DECODE.
module ctrl_alu_decode
    import multicycle_control_fsm_pkg::*;
(
    input  logic [3:0] i_opcode,
    output logic [2:0] o_alu_op,
    output logic       o_a_sel,
    output logic       o_b_sel,
    output logic       o_itype_sel,
    output logic       o_illegal
);

    always_comb begin
        o_alu_op    = ALU_ADD;
        o_a_sel     = (i_opcode != OP_LI);
        o_b_sel     = (i_opcode == OP_ADDI) || (i_opcode == OP_ORI);
        o_itype_sel = (i_opcode != OP_ORI);
        o_illegal   = !op_is_legal(i_opcode);
        // SW forwards ACC (A) as the store address; LW forwards R[rs] (B).
        case (i_opcode)
            OP_SUB:        o_alu_op = ALU_SUB;
            OP_AND:        o_alu_op = ALU_AND;
            OP_OR, OP_ORI: o_alu_op = ALU_OR;
            OP_LI, OP_SW:  o_alu_op = ALU_PASS_A;
            OP_LW:         o_alu_op = ALU_PASS_B;
            default:       o_alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control unit: sequences fetch/decode/execute/memory/writeback and drives
// every datapath strobe; memory states are guarded by a wait-cycle timeout.
//
// state    | meaning
// FETCH    | read Mem[PC], load IR, PC <= PC+1
// DECODE   | load A/B, pick next phase by opcode
// EXEC     | ALU result into ALUOut
// MEMRD    | LW data read at ALUOut
// MEMWR    | SW data write at ALUOut
// WB_ACC   | ACC <= ALUOut
// WB_MEM   | ACC <= MDR
// STORE    | R[rs] <= ACC
// BRANCH   | conditional PC-relative branch on Zero_Flag
// JUMP     | PC <= {PC[15:12], imm12}
// HALT     | idle until reset
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic [15:0] IR,
    input  logic        Zero_Flag,
    input  logic        Mem_Ready,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IorD,
    output logic        IR_Write,
    output logic        MDR_Write,
    output logic        PC_Write,
    output logic [1:0]  PCSrc,
    output logic        Awrite,
    output logic        Bwrite,
    output logic        Asel,
    output logic        Bsel,
    output logic        ITypeSel,
    output logic [2:0]  ALUOp,
    output logic        ALUOut_Write,
    output logic        ACC_Write,
    output logic        ACCSrc,
    output logic        reg_write,
    output logic        iszero_write,
    output logic        Illegal,
    output logic        Mem_Err,
    output logic        Halted,
    output logic [3:0]  State
);

    localparam int                CNT_W       = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_mem_err;
    ctrl_t            w_ctrl;

    logic [3:0] w_opcode;
    logic [2:0] w_alu_op;
    logic       w_a_sel;
    logic       w_b_sel;
    logic       w_itype_sel;
    logic       w_illegal;
    logic       w_mem_state;
    logic       w_timeout;
    logic       w_unused_ir;

    assign w_opcode    = IR[15:12];
    assign w_unused_ir = ^IR[11:0];

    ctrl_alu_decode u_alu_decode (
        .i_opcode    (w_opcode),
        .o_alu_op    (w_alu_op),
        .o_a_sel     (w_a_sel),
        .o_b_sel     (w_b_sel),
        .o_itype_sel (w_itype_sel),
        .o_illegal   (w_illegal)
    );

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign w_timeout   = w_mem_state && (r_wait_cnt == TIMEOUT_CNT);

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_timeout)
                r_mem_err <= 1'b1;
            // Any state change clears the count, so each memory state starts fresh.
            if (w_next_state != r_state)
                r_wait_cnt <= '0;
            else if (w_mem_state && !Mem_Ready)
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_ctrl       = '0;
        case (r_state)
            S_FETCH: begin
                if (w_timeout) begin
                    w_next_state = S_HALT;
                end else begin
                    w_ctrl.mem_read = 1'b1;
                    if (Mem_Ready) begin
                        w_ctrl.ir_write = 1'b1;
                        w_ctrl.pc_write = 1'b1;
                        w_ctrl.pc_src   = PCSRC_INC;
                        w_next_state    = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                w_ctrl.a_write   = 1'b1;
                w_ctrl.b_write   = 1'b1;
                w_ctrl.a_sel     = w_a_sel;
                w_ctrl.b_sel     = w_b_sel;
                w_ctrl.itype_sel = w_itype_sel;
                w_ctrl.illegal   = w_illegal;
                case (w_opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ORI,
                    OP_LI, OP_LW, OP_SW: w_next_state = S_EXEC;
                    OP_ST:               w_next_state = S_STORE;
                    OP_BEZ:              w_next_state = S_BRANCH;
                    OP_J:                w_next_state = S_JUMP;
                    OP_HALT:             w_next_state = S_HALT;
                    default:             w_next_state = S_FETCH;
                endcase
            end
            S_EXEC: begin
                w_ctrl.aluout_write = 1'b1;
                w_ctrl.alu_op       = w_alu_op;
                if (w_opcode == OP_LW)
                    w_next_state = S_MEMRD;
                else if (w_opcode == OP_SW)
                    w_next_state = S_MEMWR;
                else
                    w_next_state = S_WB_ACC;
            end
            S_MEMRD: begin
                if (w_timeout) begin
                    w_next_state = S_HALT;
                end else begin
                    w_ctrl.mem_read  = 1'b1;
                    w_ctrl.iord      = 1'b1;
                    w_ctrl.mdr_write = Mem_Ready;
                    if (Mem_Ready)
                        w_next_state = S_WB_MEM;
                end
            end
            S_MEMWR: begin
                if (w_timeout) begin
                    w_next_state = S_HALT;
                end else begin
                    w_ctrl.mem_write = 1'b1;
                    w_ctrl.iord      = 1'b1;
                    if (Mem_Ready)
                        w_next_state = S_FETCH;
                end
            end
            S_WB_ACC, S_WB_MEM: begin
                w_ctrl.acc_write    = 1'b1;
                w_ctrl.iszero_write = 1'b1;
                w_ctrl.acc_src      = (r_state == S_WB_MEM);
                w_next_state        = S_FETCH;
            end
            S_STORE: begin
                w_ctrl.reg_write = 1'b1;
                w_next_state     = S_FETCH;
            end
            S_BRANCH: begin
                w_ctrl.pc_write = Zero_Flag;
                w_ctrl.pc_src   = PCSRC_REL;
                w_next_state    = S_FETCH;
            end
            S_JUMP: begin
                w_ctrl.pc_write = 1'b1;
                w_ctrl.pc_src   = PCSRC_ABS;
                w_next_state    = S_FETCH;
            end
            S_HALT:  w_next_state = S_HALT;
            default: w_next_state = S_FETCH;
        endcase
    end

    // Outputs are forced low for the whole reset cycle so an aborted instruction writes nothing.
    assign MemRead      = Reset_n & w_ctrl.mem_read;
    assign MemWrite     = Reset_n & w_ctrl.mem_write;
    assign IorD         = Reset_n & w_ctrl.iord;
    assign IR_Write     = Reset_n & w_ctrl.ir_write;
    assign MDR_Write    = Reset_n & w_ctrl.mdr_write;
    assign PC_Write     = Reset_n & w_ctrl.pc_write;
    assign PCSrc        = Reset_n ? w_ctrl.pc_src : 2'd0;
    assign Awrite       = Reset_n & w_ctrl.a_write;
    assign Bwrite       = Reset_n & w_ctrl.b_write;
    assign Asel         = Reset_n & w_ctrl.a_sel;
    assign Bsel         = Reset_n & w_ctrl.b_sel;
    assign ITypeSel     = Reset_n & w_ctrl.itype_sel;
    assign ALUOp        = Reset_n ? w_ctrl.alu_op : 3'd0;
    assign ALUOut_Write = Reset_n & w_ctrl.aluout_write;
    assign ACC_Write    = Reset_n & w_ctrl.acc_write;
    assign ACCSrc       = Reset_n & w_ctrl.acc_src;
    assign reg_write    = Reset_n & w_ctrl.reg_write;
    assign iszero_write = Reset_n & w_ctrl.iszero_write;
    assign Illegal      = Reset_n & w_ctrl.illegal;
    assign Mem_Err      = Reset_n & r_mem_err;
    assign Halted       = Reset_n & (r_state == S_HALT);
    assign State        = Reset_n ? 4'(r_state) : 4'd0;

endmodule
